// File: rtl/gtech_arb_pkg.sv
// Shared types and helpers for the three-way
// round-robin arbiter.
package gtech_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_GNT  = 2'b01,
    S_REL  = 2'b10
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'b11;

  function automatic logic [2:0] idx_to_onehot3(
    input logic [1:0] idx
  );
    logic [2:0] oh;
    unique case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/gtech_nor3.sv
// Behavioural stand-in for the GTECH 3-input
// NOR library cell.
module GTECH_NOR3 (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Z
);

  assign Z = ~(A | B | C);

endmodule

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first
// requester after LAST in cyclic order wins.
module rr_pick3 (
  input  logic [2:0] REQ,
  input  logic [1:0] LAST,
  output logic [1:0] PICK,
  output logic       PICK_VLD
);

  logic [2:0] rot;
  logic [1:0] first;
  logic [1:0] off;
  logic [2:0] sum;

  // rotate so rot[0] is the highest-priority slot
  always_comb begin
    rot   = REQ;
    first = 2'd0;
    unique case (LAST)
      2'd0: begin
        rot   = {REQ[0], REQ[2], REQ[1]};
        first = 2'd1;
      end
      2'd1: begin
        rot   = {REQ[1], REQ[0], REQ[2]};
        first = 2'd2;
      end
      default: begin
        rot   = REQ;
        first = 2'd0;
      end
    endcase
  end

  // offset of first set bit, mapped back mod 3
  always_comb begin
    if (rot[0])
      off = 2'd0;
    else if (rot[1])
      off = 2'd1;
    else
      off = 2'd2;
    sum = {1'b0, first} + {1'b0, off};
    if (sum >= 3'd3)
      PICK = 2'(sum - 3'd3);
    else
      PICK = sum[1:0];
  end

  assign PICK_VLD = |REQ;

endmodule

// File: rtl/gtech_rr_arb3.sv
// Three-client round-robin arbiter with hold
// timeout and one dead cycle between grants.
module gtech_rr_arb3
  import gtech_arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  output logic [2:0] GNT,
  output logic [1:0] OWNER,
  output logic       TIMEOUT,
  output logic       NOREQ
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic [1:0] pick;
  logic       pick_vld;
  logic       own_req;
  logic       hit;

  GTECH_NOR3 u_nor (
    .A (REQ[0]),
    .B (REQ[1]),
    .C (REQ[2]),
    .Z (NOREQ)
  );

  rr_pick3 u_pick (
    .REQ      (REQ),
    .LAST     (last_q),
    .PICK     (pick),
    .PICK_VLD (pick_vld)
  );

  assign own_req = |(REQ & gnt_q);
  assign hit     = (HOLD_MAX != 0) &&
                   (cnt_q == HOLD_LAST);

  // state, grant and bookkeeping registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= 3'b000;
      owner_q <= OWNER_NONE;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // next-state: grant, hold, release
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_REL: begin
        if (!NOREQ && pick_vld) begin
          gnt_d   = idx_to_onehot3(pick);
          owner_d = pick;
          cnt_d   = '0;
          state_d = S_GNT;
        end else begin
          gnt_d   = 3'b000;
          owner_d = OWNER_NONE;
          state_d = S_IDLE;
        end
      end
      S_GNT: begin
        if (!own_req || hit) begin
          gnt_d   = 3'b000;
          owner_d = OWNER_NONE;
          last_d  = owner_q;
          state_d = S_REL;
          to_d    = own_req;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = 3'b000;
        owner_d = OWNER_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  assign GNT     = gnt_q;
  assign OWNER   = owner_q;
  assign TIMEOUT = to_q;

endmodule

// File: tb/tb_gtech_rr_arb3.sv
// Scoreboard bench for gtech_rr_arb3 against a
// cycle-count reference model.
module tb_gtech_rr_arb3;

  localparam int HM = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] REQ = 3'b000;
  logic [2:0] GNT;
  logic [1:0] OWNER;
  logic       TIMEOUT;
  logic       NOREQ;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] own;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  gtech_rr_arb3 #(.HOLD_MAX(HM), .CNT_W(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .GNT     (GNT),
    .OWNER   (OWNER),
    .TIMEOUT (TIMEOUT),
    .NOREQ   (NOREQ)
  );

  always #5 CLK = ~CLK;

  // reference model: owner index, last owner and
  // number of grant cycles shown so far
  initial begin
    int   m_owner;
    int   m_last;
    int   m_held;
    logic m_to;
    logic [2:0] one;
    exp_t e;
    m_owner = -1;
    m_last  = 2;
    m_held  = 0;
    m_to    = 1'b0;
    one     = 3'b001;
    forever begin
      @(posedge CLK);
      m_to = 1'b0;
      if (RST) begin
        m_owner = -1;
        m_last  = 2;
        m_held  = 0;
      end else if (m_owner >= 0) begin
        if (!REQ[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end else if (m_held == HM) begin
          m_last  = m_owner;
          m_owner = -1;
          m_to    = 1'b1;
        end else begin
          m_held++;
        end
      end else begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k) % 3;
          if (m_owner < 0 && REQ[c]) begin
            m_owner = c;
            m_held  = 1;
          end
        end
      end
      if (m_owner < 0) begin
        e.gnt = 3'b000;
        e.own = 2'b11;
      end else begin
        e.gnt = one << m_owner;
        e.own = 2'(m_owner);
      end
      e.to = m_to;
      exp_q.push_back(e);
    end
  end

  // monitor: compare registered outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (GNT !== e.gnt || OWNER !== e.own ||
            TIMEOUT !== e.to) begin
          errors++;
          $display("FAIL outputs t=%0t got gnt=%b own=%b to=%b exp gnt=%b own=%b to=%b",
                   $time, GNT, OWNER, TIMEOUT,
                   e.gnt, e.own, e.to);
        end
      end
    end
  end

  // combinational NOREQ check
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      checks++;
      if (NOREQ !== ~|REQ) begin
        errors++;
        $display("FAIL noreq t=%0t got %b exp %b",
                 $time, NOREQ, ~|REQ);
      end
    end
  end

  task automatic cyc(input logic [2:0] r,
                     input int n);
    repeat (n) begin
      @(negedge CLK);
      REQ = r;
    end
  endtask

  task automatic rst_pulse();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    cyc(3'b001, 5);
    cyc(3'b000, 3);
    cyc(3'b111, 3);
    cyc(3'b110, 1);
    cyc(3'b111, 4);
    cyc(3'b101, 1);
    cyc(3'b111, 4);
    cyc(3'b011, 1);
    cyc(3'b111, 6);
    cyc(3'b000, 3);
    cyc(3'b010, 16);
    cyc(3'b000, 3);
    cyc(3'b011, 22);
    cyc(3'b000, 3);
    cyc(3'b111, 8);
    rst_pulse();
    cyc(3'b111, 6);
    cyc(3'b000, 3);
    for (int n = 1; n <= 6; n++) begin
      cyc(3'b001, n);
      cyc(3'b000, 3);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 3) == 0)
        REQ = 3'($urandom_range(0, 7));
      RST = ($urandom_range(0, 99) == 0);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gtech_rr_arb3.md
Name: gtech_rr_arb3

Overview:
- Three-requester round-robin arbiter that shares one resource (a gate-level datapath slice or bus port) among three clients.
- Grants are one-hot and registered.
- An owner holds its grant until it drops its request, or until a hold timeout forces release.
- A one-cycle dead cycle separates consecutive grants.
- Sits between client request logic and the shared resource's select/enable inputs in GTECH-mapped netlists.

Parameters:
- HOLD_MAX, 15, maximum consecutive grant cycles per owner. 0 disables the timeout.
- CNT_W, 4, hold counter width. Must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- REQ  input  3  request per client. Bit i is client i. Level-sensitive.
- GNT  output 3  one-hot grant, registered. 000 when no owner.
- OWNER  output 2  encoded owner 0..2. 2'b11 when no owner.
- TIMEOUT  output 1  one-cycle pulse, registered, when a grant is force-released.
- NOREQ  output 1  combinational ~(REQ[0]|REQ[1]|REQ[2]).

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). All state changes occur on the rising CLK edge.
- Reset values:
  - GNT=000, OWNER=11, TIMEOUT=0.
  - State=S_IDLE, hold counter=0.
  - LAST=2, so client 0 has highest priority after reset.
- Reset asserted mid-grant takes effect at that edge. The grant drops in the following cycle, with no TIMEOUT pulse.
- Priority order from LAST: (LAST+1)%3, (LAST+2)%3, LAST.
  - The picker is combinational and evaluated only in S_IDLE and S_REL.
- States:
  - S_IDLE: GNT=000. If NOREQ=0 at an edge, register the picked client into GNT/OWNER, clear the counter, and go to S_GNT. Otherwise stay.
  - S_GNT: counter increments each cycle.
    - If REQ[OWNER]=0 at an edge: clear GNT, set OWNER=11, LAST<=owner, go to S_REL.
    - Else if HOLD_MAX!=0 and counter==HOLD_MAX-1: same release actions, plus TIMEOUT=1 for exactly the next cycle. This is a forced release.
    - Requests from non-owners are ignored in S_GNT.
  - S_REL: one dead cycle, GNT=000. Arbitrate using the updated LAST.
    - Any request: grant at this edge, go to S_GNT.
    - No request: go to S_IDLE.
- Latency:
  - REQ sampled high at edge k in S_IDLE gives GNT high from edge k onward (visible in cycle k+1).
  - Owner drop at edge k gives GNT=000 in cycle k+1. The next grant is visible at cycle k+2.
- Maximum grant length: HOLD_MAX cycles when HOLD_MAX!=0.
- A force-released owner still requesting becomes lowest priority. If it is the only requester, it is re-granted after the dead cycle.
- Simultaneous events:
  - Owner drops REQ on the same edge the timeout hits: treated as a normal release, TIMEOUT=0.
  - All three requesting: grants rotate 0→1→2→0 from reset.
- GNT is never multi-hot. OWNER and GNT are always consistent.
- Counter never wraps. It is cleared on every grant and cannot exceed HOLD_MAX-1.

Decomposition:
- Package gtech_arb_pkg:
  - State encoding: S_IDLE=2'b00, S_GNT=2'b01, S_REL=2'b10.
  - OWNER_NONE=2'b11.
  - Function idx_to_onehot3.
- Sub-module rr_pick3 (combinational):
  - Inputs: REQ[2:0], LAST[1:0].
  - Outputs: PICK[1:0], PICK_VLD.
- NOREQ is built from a GTECH_NOR3 instance so the netlist maps directly to a library cell.

Test Plan:
- Reset then REQ=001 held for 5 cycles, then dropped:
  - GNT=001 from cycle 1 to cycle 5.
  - GNT=000 in the dead cycle.
  - State returns to S_IDLE; OWNER=11.
- REQ=111 held constant, HOLD_MAX=15, each owner drops its REQ after 3 cycles of grant, then re-asserts:
  - Grant sequence 001, 010, 100, 001.
  - Each grant is separated by exactly one GNT=000 cycle.
- REQ=010 held forever, HOLD_MAX=4:
  - GNT=010 for 4 cycles, then TIMEOUT=1 for one cycle with GNT=000.
  - Re-grant to 010; the pattern repeats every 5 cycles.
- REQ=011 held, HOLD_MAX=4:
  - Client 0 times out, then client 1 is granted.
  - Client 1 times out, then client 0 is granted. Strict alternation.
- RST pulsed while GNT=100:
  - GNT=000, OWNER=11 and TIMEOUT=0 in the next cycle.
  - With REQ=111, the first post-reset grant is 001.
- Owner drops REQ on the same edge the counter reaches HOLD_MAX-1:
  - TIMEOUT stays 0 and LAST is updated.
  - NOREQ tracks ~|REQ combinationally in every cycle.
